// File: rtl/prod_accumulator.sv
// Burst accumulator for signed 8-bit products with saturation,
// valid/ready input and output handshakes, and a sticky overflow flag.
module prod_accumulator #(
    parameter int ACC_W = 12,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       prod,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [ACC_W-1:0] MAXV = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] MINV = {1'b1, {(ACC_W-1){1'b0}}};

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovf_q, ovf_d;

    logic [ACC_W:0]     sum;
    logic               clamp;
    logic               beat;

    // One guard bit: the top two bits disagree exactly when the sum overflows.
    assign sum   = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-7){prod[7]}}, prod};
    assign clamp = sum[ACC_W] ^ sum[ACC_W-1];
    assign beat  = in_valid && (state_q == ACCUM);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = len;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (beat) begin
                    if (clamp) begin
                        acc_d = sum[ACC_W] ? MINV : MAXV;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = sum[ACC_W-1:0];
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == len_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign acc_out   = acc_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_prod_accumulator.sv
// Random and directed bursts against two widths (12 and 9 bits)
// compared with an integer saturating reference model.
module tb_prod_accumulator;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [3:0]        len;
    logic [7:0]        prod;
    logic              in_valid;
    logic              out_ready;

    logic              rdy12, vld12, ovf12, busy12;
    logic signed [11:0] acc12;
    logic              rdy9, vld9, ovf9, busy9;
    logic signed [8:0] acc9;

    int n_cmp;
    int n_bad;
    int pr[16];
    int gp[16];
    int m12, m9;
    int f12, f9;

    always #5 clk = ~clk;

    prod_accumulator #(.ACC_W(12), .LEN_W(4)) u12 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .prod(prod), .in_valid(in_valid), .in_ready(rdy12),
        .acc_out(acc12), .out_valid(vld12), .out_ready(out_ready),
        .ovf(ovf12), .busy(busy12)
    );

    prod_accumulator #(.ACC_W(9), .LEN_W(4)) u9 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .prod(prod), .in_valid(in_valid), .in_ready(rdy9),
        .acc_out(acc9), .out_valid(vld9), .out_ready(out_ready),
        .ovf(ovf9), .busy(busy9)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int lo, hi;
        lo = -(1 << (w - 1));
        hi = (1 << (w - 1)) - 1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic model_beat(input int p);
        int s;
        s = m12 + p;
        if (sat(s, 12) != s) f12 = 1;
        m12 = sat(s, 12);
        s = m9 + p;
        if (sat(s, 9) != s) f9 = 1;
        m9 = sat(s, 9);
    endtask

    task automatic check_ctl(input string tag, input int rdy,
                             input int vld, input int bsy);
        check({tag, "_rdy12"}, int'(rdy12), rdy);
        check({tag, "_vld12"}, int'(vld12), vld);
        check({tag, "_busy12"}, int'(busy12), bsy);
        check({tag, "_rdy9"}, int'(rdy9), rdy);
        check({tag, "_vld9"}, int'(vld9), vld);
        check({tag, "_busy9"}, int'(busy9), bsy);
    endtask

    task automatic check_acc(input string tag);
        check({tag, "_acc12"}, int'(acc12), m12);
        check({tag, "_ovf12"}, int'(ovf12), f12);
        check({tag, "_acc9"}, int'(acc9), m9);
        check({tag, "_ovf9"}, int'(ovf9), f9);
    endtask

    // Entered and left at a falling edge with the blocks in IDLE.
    task automatic burst(input int ln, input int hold, input bit inj);
        check_ctl("idle", 0, 0, 0);
        start = 1'b1;
        len   = 4'(ln);
        @(negedge clk);
        start = 1'b0;
        len   = 4'($urandom);
        m12 = 0; m9 = 0; f12 = 0; f9 = 0;
        check_ctl("accum", 1, 0, 1);
        check_acc("cleared");
        for (int i = 0; i <= ln; i++) begin
            for (int g = 0; g < gp[i]; g++) begin
                in_valid = 1'b0;
                prod     = 8'($urandom);
                if (inj) begin
                    start = 1'b1;
                    len   = 4'd0;
                end
                @(negedge clk);
                start = 1'b0;
                check_ctl("gap", 1, 0, 1);
                check_acc("gap");
            end
            check_acc("pre_beat");
            check_ctl("pre_beat", 1, 0, 1);
            in_valid = 1'b1;
            prod     = pr[i][7:0];
            if (inj && i == 0) begin
                start = 1'b1;
                len   = 4'd0;
            end
            @(negedge clk);
            in_valid = 1'b0;
            start    = 1'b0;
            model_beat(pr[i]);
        end
        check_ctl("done", 0, 1, 1);
        check_acc("done");
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            @(negedge clk);
            check_ctl("held", 0, 1, 1);
            check_acc("held");
        end
        out_ready = 1'b1;
        if (inj) begin
            start = 1'b1;
            len   = 4'd0;
        end
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        check_ctl("handoff", 0, 0, 0);
        check_acc("idle_hold");
        @(negedge clk);
        check_ctl("no_restart", 0, 0, 0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        m12 = 0; m9 = 0; f12 = 0; f9 = 0;
        rst_n = 1'b0; start = 1'b0; len = '0; prod = '0;
        in_valid = 1'b0; out_ready = 1'b0;
        #2;
        check_ctl("rst", 0, 0, 0);
        check_acc("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        pr[0] = 64; pr[1] = -56; pr[2] = 10; pr[3] = -1;
        for (int i = 0; i < 16; i++) gp[i] = 0;
        burst(3, 0, 1'b0);
        check("basic_sum", int'(acc12), 17);

        pr[0] = 5; pr[1] = 7; gp[1] = 3;
        burst(1, 4, 1'b0);
        check("gapped_sum", int'(acc12), 12);
        gp[1] = 0;

        for (int i = 0; i < 5; i++) pr[i] = 127;
        burst(4, 0, 1'b0);
        check("sat_acc9", int'(acc9), 255);
        check("sat_ovf9", int'(ovf9), 1);
        check("sat_acc12", int'(acc12), 635);
        pr[0] = -3;
        burst(0, 0, 1'b0);
        check("after_sat_acc9", int'(acc9), -3);
        check("after_sat_ovf9", int'(ovf9), 0);

        for (int i = 0; i < 16; i++) begin
            pr[i] = int'($urandom_range(0, 255)) - 128;
            gp[i] = (i % 2 == 1) ? 1 : 0;
        end
        burst(5, 1, 1'b1);

        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < 16; i++) begin
                pr[i] = int'($urandom_range(0, 255)) - 128;
                gp[i] = int'($urandom_range(0, 2));
            end
            burst(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)));
        end

        start = 1'b1; len = 4'd3;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; prod = 8'd100;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        m12 = 0; m9 = 0; f12 = 0; f9 = 0;
        #1;
        check_ctl("async_rst", 0, 0, 0);
        check_acc("async_rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_ctl("post_rst", 0, 0, 0);
        end
        pr[0] = -128; gp[0] = 0;
        burst(0, 0, 1'b0);
        check("fresh_acc12", int'(acc12), -128);
        check("fresh_acc9", int'(acc9), -128);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prod_accumulator.md
PROD_ACCUMULATOR -- requirements
Module: prod_accumulator

Interface
REQ-001 Parameter ACC_W, default 12, accumulator and result width in bits; legal range 9..16.
REQ-002 Parameter LEN_W, default 4, width of the burst-length field.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 len  input  LEN_W  burst length minus one, so 0..15 means 1..16 products; sampled with start.
REQ-007 prod  input  8  signed two's-complement product from the upstream 4x4 signed multiplier.
REQ-008 in_valid  input  1  prod is valid this cycle.
REQ-009 in_ready  output  1  block accepts prod this cycle.
REQ-010 acc_out  output  ACC_W  signed burst sum.
REQ-011 out_valid  output  1  acc_out holds a completed burst result.
REQ-012 out_ready  input  1  downstream accepts acc_out.
REQ-013 ovf  output  1  saturation occurred during the current or last burst.
REQ-014 busy  output  1  high in ACCUM and DONE.

Function
REQ-015 The FSM SHALL have three states, IDLE, ACCUM and DONE, with registered state.
REQ-016 IDLE with start=1 SHALL perform all of the following:
- latch len into len_q
- clear the accumulator, the beat counter and ovf
- go to ACCUM on the next edge
REQ-017 IDLE with start=0 SHALL hold all state.
REQ-018 start asserted in ACCUM or DONE SHALL be ignored, with no effect on len_q, the accumulator or the counter.
REQ-019 in_ready SHALL be 1 exactly when the state is ACCUM; it is a registered-state decode with no combinational path from in_valid.
REQ-020 A beat is in_valid=1 and in_ready=1.
REQ-021 On each beat, acc SHALL be updated to sat(acc + sign_extend(prod)), and the counter SHALL increment.
REQ-022 No state SHALL change in ACCUM without a beat; in_valid gaps are allowed.
REQ-023 sat() SHALL clamp the ACC_W+1-bit exact sum to the range [-2^(ACC_W-1), 2^(ACC_W-1)-1].
REQ-024 Any clamp SHALL set ovf, which stays set (sticky) until the next accepted start or reset.
REQ-025 The beat taken when counter==len_q SHALL be the last beat of the burst: it updates acc and moves to DONE on the same edge.
REQ-026 Latency: out_valid SHALL rise on the clock edge after the last beat.
REQ-027 In DONE, out_valid SHALL be 1 and acc_out SHALL equal acc, held stable until the handshake.
REQ-028 In DONE with out_ready=1, the block SHALL return to IDLE on the next edge, with out_valid low on that same edge.
REQ-029 acc and ovf SHALL keep their values in IDLE until the next accepted start.
REQ-030 acc_out SHALL reflect acc in every state; consumers qualify it with out_valid.
REQ-031 In DONE with out_ready=1 and start=1 in the same cycle, the block SHALL go to IDLE only; the start is dropped.
REQ-032 The counter is LEN_W bits and SHALL never wrap within a burst, because the state exits at len_q.
REQ-033 With ACC_W>=12, no legal input stream can saturate (16 × ±128 fits); saturation is exercised with a reduced ACC_W.

Reset
REQ-034 While rst_n=0, the block SHALL hold, asynchronously and independent of clk:
- state=IDLE
- acc, acc_out, counter and len_q = 0
- in_ready, out_valid, ovf and busy = 0
REQ-035 Reset asserted mid-burst SHALL abandon the burst; no partial result is presented.
REQ-036 After rst_n deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-037 Reset values: drive rst_n=0 asynchronously mid-cycle -> all outputs 0 before the next clk edge.
REQ-038 Basic burst: start with len=3, products 64, -56, 10, -1 with no gaps -> out_valid one cycle after the 4th beat, acc_out=17, ovf=0.
REQ-039 Gapped input and backpressure:
- Stimulus: len=1, products 5 and 7, in_valid low for 3 cycles between them, out_ready held low for 4 cycles.
- Response: acc_out=12 held stable with out_valid=1 for those 4 cycles, then IDLE one cycle after out_ready=1.
REQ-040 Saturation: ACC_W=9, len=4, five products of 127 -> acc_out=255, ovf=1; then a new start with len=0 and prod=-3 -> acc_out=-3, ovf=0.
REQ-041 Ignored start:
- Stimulus: start pulsed during ACCUM with len=0, and again in the DONE cycle where out_ready=1.
- Response: the original len burst completes unchanged; the state is IDLE afterwards, not ACCUM.
REQ-042 Reset mid-burst: rst_n low after 2 of 4 beats -> out_valid never rises; a fresh len=0 burst with prod=-128 -> acc_out=-128.
